// File: rtl/i_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, addresses the async-read ROM and
// presents one registered instruction at a time to decode over valid/ready.
package i_fetch_pkg;
  localparam int WORD_SIZE_P   = 32;
  localparam int I_ROM_DEPTH_P = 64;
endpackage

module i_fetch_ctrl
  import i_fetch_pkg::*;
#(
  parameter int RESET_PC_P = 0,
  localparam int ADDR_WIDTH_LP = $clog2(I_ROM_DEPTH_P)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     start_i,
  input  logic                     halt_i,
  input  logic                     redirect_v_i,
  input  logic [ADDR_WIDTH_LP-1:0] redirect_pc_i,
  output logic [ADDR_WIDTH_LP-1:0] rom_addr_o,
  input  logic [WORD_SIZE_P-1:0]   rom_data_i,
  output logic [WORD_SIZE_P-1:0]   inst_o,
  output logic [ADDR_WIDTH_LP-1:0] inst_pc_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     halted_o,
  output logic [15:0]              fetch_count_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH_LP-1:0] RESET_PC_LP = ADDR_WIDTH_LP'(RESET_PC_P);
  localparam logic [ADDR_WIDTH_LP-1:0] LAST_PC_LP  = ADDR_WIDTH_LP'(I_ROM_DEPTH_P - 1);

  state_e                   state_q, state_d;
  logic [ADDR_WIDTH_LP-1:0] pc_q, pc_d;
  logic [WORD_SIZE_P-1:0]   inst_q, inst_d;
  logic [ADDR_WIDTH_LP-1:0] inst_pc_q, inst_pc_d;
  logic                     valid_q, valid_d;
  logic                     halted_q, halted_d;
  logic [15:0]              count_q, count_d;
  logic                     run_s;
  logic                     load_s;
  logic [ADDR_WIDTH_LP-1:0] next_pc_s;

  assign run_s      = (state_q == RUN);
  assign rom_addr_o = (run_s && redirect_v_i) ? redirect_pc_i : pc_q;
  // Halt wins over every load; a redirect forces a load even under back-pressure.
  assign load_s     = run_s && !halt_i && (redirect_v_i || !valid_q || ready_i);
  // Explicit wrap keeps the sequence correct for non-power-of-two depths too.
  assign next_pc_s  = (rom_addr_o == LAST_PC_LP) ? '0 : rom_addr_o + ADDR_WIDTH_LP'(1);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    count_d   = count_q + {15'd0, (valid_q & ready_i)};
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (halt_i) begin
          state_d  = HALT;
          valid_d  = 1'b0;
          halted_d = 1'b1;
        end else if (load_s) begin
          inst_d    = rom_data_i;
          inst_pc_d = rom_addr_o;
          valid_d   = 1'b1;
          pc_d      = next_pc_s;
        end else begin
          valid_d = valid_q;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC_LP;
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      count_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
      count_q   <= count_d;
    end
  end

  assign inst_o        = inst_q;
  assign inst_pc_o     = inst_pc_q;
  assign valid_o       = valid_q;
  assign halted_o      = halted_q;
  assign fetch_count_o = count_q;

endmodule

// File: tb/tb_i_fetch_ctrl.sv
// Directed bench for i_fetch_ctrl with a behavioural async-read ROM.
module tb_i_fetch_ctrl;
  import i_fetch_pkg::*;

  localparam int AW = $clog2(I_ROM_DEPTH_P);

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          start_i, halt_i, redirect_v_i, ready_i;
  logic [AW-1:0] redirect_pc_i;
  logic [AW-1:0] rom_addr_o;
  logic [WORD_SIZE_P-1:0] rom_data_i, inst_o;
  logic [AW-1:0] inst_pc_o;
  logic          valid_o, halted_o;
  logic [15:0]   fetch_count_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  // ROM word i holds C0DE_00ii so every word is distinguishable from its address.
  assign rom_data_i = 32'hC0DE_0000 + {{(32-AW){1'b0}}, rom_addr_o};

  i_fetch_ctrl #(.RESET_PC_P(0)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .halt_i(halt_i),
    .redirect_v_i(redirect_v_i), .redirect_pc_i(redirect_pc_i),
    .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i), .inst_o(inst_o),
    .inst_pc_o(inst_pc_o), .valid_o(valid_o), .ready_i(ready_i),
    .halted_o(halted_o), .fetch_count_o(fetch_count_o)
  );

  function automatic logic [31:0] w(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input int pc, input int cnt);
    chk({tag, "_valid"}, {31'd0, valid_o}, {31'd0, v});
    chk({tag, "_pc"}, 32'(inst_pc_o), 32'(pc));
    chk({tag, "_inst"}, inst_o, v ? w(pc) : inst_o);
    chk({tag, "_cnt"}, 32'(fetch_count_o), 32'(cnt));
  endtask

  initial begin
    reset_n_i = 1'b0; start_i = 1'b0; halt_i = 1'b0;
    redirect_v_i = 1'b0; redirect_pc_i = '0; ready_i = 1'b0;
    step(); step();
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_instpc", 32'(inst_pc_o), 32'd0);
    chk("rst_cnt", 32'(fetch_count_o), 32'd0);
    chk("rst_halted", {31'd0, halted_o}, 32'd0);
    chk("rst_romaddr", 32'(rom_addr_o), 32'd0);
    #2 reset_n_i = 1'b1;
    ready_i = 1'b1; redirect_v_i = 1'b1; redirect_pc_i = AW'(9);
    step(); step();
    chk("idle_valid", {31'd0, valid_o}, 32'd0);
    chk("idle_romaddr", 32'(rom_addr_o), 32'd0);
    redirect_v_i = 1'b0;

    // start: RUN after this edge, first load one edge later
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("start_lat_valid", {31'd0, valid_o}, 32'd0);
    step(); chk_out("A", 1'b1, 0, 0);
    step(); chk_out("B", 1'b1, 1, 1);

    // back-pressure on B
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk_out("bp", 1'b1, 1, 1);
    end
    ready_i = 1'b1;
    step(); chk_out("C", 1'b1, 2, 2);
    step(); chk_out("D", 1'b1, 3, 3);
    step(); chk_out("E", 1'b1, 4, 4);
    step(); chk_out("F", 1'b1, 5, 5);

    // redirect while PC 5 is being accepted
    redirect_v_i = 1'b1; redirect_pc_i = AW'(32);
    #1 chk("redir_romaddr", 32'(rom_addr_o), 32'd32);
    step(); chk_out("redir", 1'b1, 32, 6);
    redirect_v_i = 1'b0;
    step(); chk_out("redir_next", 1'b1, 33, 7);

    // wrap-around at the top of the ROM
    redirect_v_i = 1'b1; redirect_pc_i = AW'(I_ROM_DEPTH_P - 2);
    step(); chk_out("wrap0", 1'b1, I_ROM_DEPTH_P - 2, 8);
    redirect_v_i = 1'b0;
    step(); chk_out("wrap1", 1'b1, I_ROM_DEPTH_P - 1, 9);
    step(); chk_out("wrap2", 1'b1, 0, 10);
    step(); chk_out("wrap3", 1'b1, 1, 11);

    // redirect under back-pressure drops the held word without counting it
    ready_i = 1'b0; redirect_v_i = 1'b1; redirect_pc_i = AW'(10);
    step(); chk_out("redir_bp", 1'b1, 10, 11);

    // halt together with redirect; the accept in that cycle counts
    ready_i = 1'b1; halt_i = 1'b1; redirect_pc_i = AW'(48);
    step();
    chk("halt_valid", {31'd0, valid_o}, 32'd0);
    chk("halt_halted", {31'd0, halted_o}, 32'd1);
    chk("halt_cnt", 32'(fetch_count_o), 32'd12);
    chk("halt_instpc", 32'(inst_pc_o), 32'd10);
    chk("halt_romaddr", 32'(rom_addr_o), 32'd11);
    halt_i = 1'b0; start_i = 1'b1;
    step(); step(); step();
    chk("halt_stay_valid", {31'd0, valid_o}, 32'd0);
    chk("halt_stay_halted", {31'd0, halted_o}, 32'd1);
    chk("halt_stay_cnt", 32'(fetch_count_o), 32'd12);
    chk("halt_stay_romaddr", 32'(rom_addr_o), 32'd11);

    // asynchronous reset out of HALT
    redirect_v_i = 1'b0; start_i = 1'b0;
    #2 reset_n_i = 1'b0;
    #1 chk("rst_halt_halted", {31'd0, halted_o}, 32'd0);
    chk("rst_halt_cnt", 32'(fetch_count_o), 32'd0);
    #1 reset_n_i = 1'b1;
    step();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step(); chk_out("r2_0", 1'b1, 0, 0);
    step(); chk_out("r2_1", 1'b1, 1, 1);
    step(); chk_out("r2_2", 1'b1, 2, 2);

    // asynchronous reset mid-run, between edges
    #3 reset_n_i = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, valid_o}, 32'd0);
    chk("mid_rst_inst", inst_o, 32'd0);
    chk("mid_rst_cnt", 32'(fetch_count_o), 32'd0);
    chk("mid_rst_romaddr", 32'(rom_addr_o), 32'd0);
    #2 reset_n_i = 1'b1;
    chk("post_rst_romaddr", 32'(rom_addr_o), 32'd0);
    step(); step();
    chk("post_rst_idle_valid", {31'd0, valid_o}, 32'd0);
    chk("post_rst_idle_cnt", 32'(fetch_count_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i_fetch_ctrl.md
# i_fetch_ctrl

Fetch sequencer for the front end. Owns the program counter, drives the address of the asynchronous-read instruction ROM, and registers each returned word into a one-entry output stage. The output stage hands instructions to decode over a valid/ready handshake. The block handles start-up, back-pressure, branch redirects and halt.

## Interface

**Parameters**
- WORD_SIZE_P, package constant: instruction width in bits.
- I_ROM_DEPTH_P, package constant: ROM depth in words.
- RESET_PC_P, default 0: PC loaded at reset.
- ADDR_WIDTH_LP, localparam, $clog2(I_ROM_DEPTH_P): PC and ROM address width (word addressed).

**Ports**
- clk_i, input, 1: the single clock.
- reset_n_i, input, 1: asynchronous, active-low reset.
- start_i, input, 1: level; leaves IDLE.
- halt_i, input, 1: back-end halt request.
- redirect_v_i, input, 1: branch/jump redirect valid.
- redirect_pc_i, input, ADDR_WIDTH_LP: redirect target.
- rom_addr_o, output, ADDR_WIDTH_LP: to ROM r_addr_i.
- rom_data_i, input, WORD_SIZE_P: from ROM data_o, valid in the same cycle.
- inst_o, output, WORD_SIZE_P: registered instruction.
- inst_pc_o, output, ADDR_WIDTH_LP: PC of inst_o.
- valid_o, output, 1: inst_o valid.
- ready_i, input, 1: decode accepts.
- halted_o, output, 1: high in HALT.
- fetch_count_o, output, 16: count of accepted instructions.

## Operation

**States**
- IDLE: entered at reset.
- RUN: entered from IDLE when start_i=1.
- HALT: entered from RUN when halt_i=1.
- HALT is left only by reset. No other transitions.

**Reset values**
- pc_r=RESET_PC_P, inst_o=0, inst_pc_o=0, valid_o=0, halted_o=0, fetch_count_o=0.
- rom_addr_o=pc_r, so it reads RESET_PC_P.

**ROM address**
- rom_addr_o = redirect_v_i ? redirect_pc_i : pc_r when in RUN with redirect_v_i=1.
- Otherwise rom_addr_o = pc_r. This is combinational.

**Load condition (RUN only)**
- load = redirect_v_i | ~valid_o | (valid_o & ready_i).
- On load: inst_o<=rom_data_i, inst_pc_o<=rom_addr_o, valid_o<=1, pc_r<=rom_addr_o+1.
- The increment is modulo I_ROM_DEPTH_P: depth-1 wraps to 0, also for a power-of-two truncation.

**Redirect**
- A redirect discards any held instruction, even if valid_o&ready_i in the same cycle.
- That instruction is still counted as accepted when ready_i=1.
- The output register is then filled from the redirect target in the same edge.

**Back-pressure**
- With valid_o=1, ready_i=0 and no redirect, inst_o, inst_pc_o and pc_r hold.

**Accept counter**
- fetch_count_o increments by 1 on each cycle with valid_o&ready_i.
- It is 16 bits and wraps.

**IDLE**
- No loads; redirect_v_i and ready_i are ignored; valid_o=0.

**HALT entry and behaviour**
- halt_i in RUN has priority over redirect and load.
- On that edge: valid_o<=0, no load, pc_r holds, and an accept in that cycle is still counted.
- In HALT: halted_o=1, valid_o=0, all inputs except reset are ignored.

**Reset mid-operation**
- reset_n_i low forces all reset values immediately, in any state.

## Timing

- **Start latency:** start_i sampled high at edge N moves the block to RUN. The first load occurs at edge N+1, so valid_o=1 from N+1 with inst_pc_o=RESET_PC_P.
- **Streaming:** with ready_i held at 1, one instruction is delivered per cycle at consecutive PCs.
- **Redirect latency:** redirect_v_i high in cycle C gives inst_pc_o=redirect_pc_i with valid_o=1 after edge C. There are no bubbles.
- **Halt:** valid_o deasserts and halted_o asserts on the edge that samples halt_i.
- **Critical path:** the only combinational path is redirect_pc_i through rom_addr_o, the ROM and the inst_o D-input.

## Test plan

- **Reset and start:** hold reset_n_i low, then release, with ROM[0..3]=A,B,C,D. Outputs stay at reset values in IDLE. Pulse start_i and hold ready_i=1. Required: inst_o=A,B,C,D on successive cycles, inst_pc_o=0..3, fetch_count_o=4.
- **Back-pressure:** drop ready_i for 3 cycles while inst_o=B. Required: inst_o=B, inst_pc_o=1 and valid_o stay stable, fetch_count_o is unchanged, and C follows once ready_i returns.
- **Redirect with accept:** assert redirect_v_i with redirect_pc_i=0x20 while valid_o&ready_i at PC 5. Required: next inst_pc_o=0x20, the PC 6 word is never presented, and fetch_count_o increments once.
- **Wrap-around:** redirect to I_ROM_DEPTH_P-2. Required: inst_pc_o sequence depth-2, depth-1, 0, 1.
- **Halt with redirect:** assert halt_i and redirect_v_i together. Required: next cycle valid_o=0 and halted_o=1. Later start_i, redirect_v_i and ready_i have no effect until reset.
- **Mid-run reset:** assert reset_n_i low asynchronously, between clock edges. Required: valid_o, inst_o and fetch_count_o go to 0 immediately. After release, rom_addr_o=RESET_PC_P and the block is in IDLE.
